// File: rtl/autosa_rbk_sreg_pkg.sv
// Shared constants for the Rubik multi-channel status/pointer register block.
// Holds the per-channel register offsets, the global summary offset, the
// interrupt event bit positions and the channel-count ceiling.
package autosa_rbk_sreg_pkg;

    localparam int MAX_CH = 16;

    // Per-channel register offsets within a channel's 16-byte slot
    localparam logic [3:0] OFF_STATUS   = 4'h0;
    localparam logic [3:0] OFF_POINTER  = 4'h4;
    localparam logic [3:0] OFF_INTR_STS = 4'h8;
    localparam logic [3:0] OFF_INTR_EN  = 4'hC;

    // Global summary register and channel slot size, relative to the window base
    localparam logic [8:0] OFF_INTR_SUM = 9'h100;
    localparam logic [8:0] CH_STRIDE    = 9'h010;

    // Interrupt event bit positions in INTR_STS / INTR_EN
    localparam int CONS_ADV = 0;
    localparam int DRAINED  = 1;

    // Word index of a register inside a channel slot (offset bits [3:2])
    typedef enum logic [1:0] {
        REG_STATUS   = 2'd0,
        REG_POINTER  = 2'd1,
        REG_INTR_STS = 2'd2,
        REG_INTR_EN  = 2'd3
    } chan_reg_e;

endpackage

// File: rtl/autosa_rbk_sreg_chan.sv
// One channel of the Rubik register block: producer pointer, sticky W1C
// interrupt events with enables, and the event detectors watching the
// datapath's consumer pointer and the derived pending count.
module autosa_rbk_sreg_chan
    import autosa_rbk_sreg_pkg::*;
#(
    parameter int PTR_W = 8,
    parameter int STS_W = 2
) (
    input  logic             autosa_core_clk,
    input  logic             autosa_core_rstn,
    input  logic [PTR_W-1:0] consumer,
    input  logic [STS_W-1:0] status,
    input  chan_reg_e        rd_sel,
    input  logic [31:0]      wr_data,
    input  logic             wr_ptr,
    input  logic             wr_ists,
    input  logic             wr_ien,
    output logic [PTR_W-1:0] producer,
    output logic [31:0]      rd_word,
    output logic             pend_evt
);

    logic [PTR_W-1:0] consumer_d;
    logic [PTR_W-1:0] pending;
    logic [PTR_W-1:0] pending_d;
    logic             armed;
    logic [1:0]       intr_sts;
    logic [1:0]       intr_en;
    logic [1:0]       evt_set;
    logic [1:0]       evt_clr;
    logic             unused_wr;

    assign unused_wr = ^wr_data;

    // Pending count wraps naturally in PTR_W bits
    assign pending  = producer - consumer;
    assign pend_evt = |(intr_sts & intr_en);

    // Hardware event detection and software clear mask; armed masks the first cycle after reset
    always_comb begin
        evt_set           = 2'b00;
        evt_set[CONS_ADV] = armed && (consumer != consumer_d);
        evt_set[DRAINED]  = armed && (pending_d != '0) && (pending == '0);
        evt_clr           = wr_ists ? wr_data[1:0] : 2'b00;
    end

    // Channel state; a hardware set overrides a same-cycle software clear
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            producer   <= '0;
            consumer_d <= '0;
            pending_d  <= '0;
            armed      <= 1'b0;
            intr_sts   <= 2'b00;
            intr_en    <= 2'b00;
        end else begin
            consumer_d <= consumer;
            pending_d  <= pending;
            armed      <= 1'b1;
            intr_sts   <= (intr_sts & ~evt_clr) | evt_set;
            if (wr_ptr) begin
                producer <= wr_data[PTR_W-1:0];
            end
            if (wr_ien) begin
                intr_en <= wr_data[1:0];
            end
        end
    end

    // Read word for the selected register of this channel; unused bits stay 0
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            REG_STATUS: begin
                rd_word[STS_W-1:0]  = status;
                rd_word[16+:PTR_W]  = pending;
            end
            REG_POINTER: begin
                rd_word[PTR_W-1:0]  = producer;
                rd_word[16+:PTR_W]  = consumer;
            end
            REG_INTR_STS: rd_word[1:0] = intr_sts;
            REG_INTR_EN:  rd_word[1:0] = intr_en;
            default:      rd_word = '0;
        endcase
    end

endmodule

// File: rtl/autosa_rbk_multi_ch_reg.sv
// Rubik status/pointer register block for NUM_CH producer/consumer channels.
// Decodes the CSB offset into a channel slot or the global INTR_SUM register,
// muxes read data and registers the merged interrupt.
// Build option AUTOSA_RBK_SREG_RDREG_EN: when defined, reg_rd_data is
// registered (one cycle behind reg_offset); otherwise it is combinational.
module autosa_rbk_multi_ch_reg
    import autosa_rbk_sreg_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          PTR_W       = 8,
    parameter int          STS_W       = 2,
    parameter logic [11:0] BASE_OFFSET = 12'h000
) (
    input  logic                    autosa_core_clk,
    input  logic                    autosa_core_rstn,
    input  logic [11:0]             reg_offset,
    input  logic [31:0]             reg_wr_data,
    input  logic                    reg_wr_en,
    output logic [31:0]             reg_rd_data,
    output logic [NUM_CH*PTR_W-1:0] producer,
    input  logic [NUM_CH*PTR_W-1:0] consumer,
    input  logic [NUM_CH*STS_W-1:0] status,
    output logic                    intr
);

    logic              in_window;
    logic [8:0]        rel;
    logic              chan_region;
    logic              sum_hit;
    chan_reg_e         reg_sel;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] intr_sum;
    logic [31:0]       chan_rd [NUM_CH];
    logic [31:0]       rd_comb;

    // The window is 512-byte aligned, so the low nine offset bits are window-relative
    assign in_window   = (reg_offset[11:9] == BASE_OFFSET[11:9]);
    assign rel         = reg_offset[8:0];
    assign chan_region = in_window && !rel[8] && (rel[1:0] == 2'b00);
    assign sum_hit     = in_window && (rel == OFF_INTR_SUM);
    assign reg_sel     = chan_reg_e'(rel[3:2]);

    // Channel slots are CH_STRIDE apart, so bits [7:4] pick the channel
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_sel[i] = chan_region && (rel[7:4] == 4'(i));

        autosa_rbk_sreg_chan #(
            .PTR_W (PTR_W),
            .STS_W (STS_W)
        ) u_chan (
            .autosa_core_clk  (autosa_core_clk),
            .autosa_core_rstn (autosa_core_rstn),
            .consumer         (consumer[i*PTR_W +: PTR_W]),
            .status           (status[i*STS_W +: STS_W]),
            .rd_sel           (reg_sel),
            .wr_data          (reg_wr_data),
            .wr_ptr           (ch_sel[i] && reg_wr_en && (reg_sel == REG_POINTER)),
            .wr_ists          (ch_sel[i] && reg_wr_en && (reg_sel == REG_INTR_STS)),
            .wr_ien           (ch_sel[i] && reg_wr_en && (reg_sel == REG_INTR_EN)),
            .producer         (producer[i*PTR_W +: PTR_W]),
            .rd_word          (chan_rd[i]),
            .pend_evt         (intr_sum[i])
        );
    end

    // Read mux: selected channel word, INTR_SUM, or 0 for anything unmapped
    always_comb begin
        rd_comb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                rd_comb = rd_comb | chan_rd[i];
            end
        end
        if (sum_hit) begin
            rd_comb = 32'(intr_sum);
        end
    end

    // Merged interrupt toward the core aggregator, registered
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            intr <= 1'b0;
        end else begin
            intr <= |intr_sum;
        end
    end

`ifdef AUTOSA_RBK_SREG_RDREG_EN
    // Registered read data, valid the cycle after the offset is presented
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            reg_rd_data <= '0;
        end else begin
            reg_rd_data <= rd_comb;
        end
    end
`else
    assign reg_rd_data = rd_comb;
`endif

endmodule
